// File: rtl/armleocpu_jtag_dtm.sv
// armleocpu_jtag_dtm
// RISC-V Debug Transport Module DR logic behind armleocpu_jtag_tap. Decodes the
// TAP instruction, owns the DTMCS and DMI shift registers, drives the TAP's
// custom-DR serial input, and turns DMI scans into valid/ready requests toward
// the Debug Module, collecting the responses.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   ir_i                   current TAP instruction
//   trst_ni                TAP logic-reset strobe (active-low, synchronous)
//   capture_i/shift_i/update_i  one-clk DR strobes from the TAP
//   td_i / tdo_o           serial data in / out
//   dmi_req_*              request channel (op 1 = read, 2 = write)
//   dmi_resp_*             response channel (op 0 ok, 2 failed, 3 busy)
//
// Configuration:
//   ARMLEOCPU_JTAG_DTM_HARDRESET_EN  enables DTMCS.dmihardreset (and hardreset
//   on trst_ni): clears sticky and discards the response of an in-flight access.

module armleocpu_jtag_dtm #(
   parameter int unsigned          IR_LENGTH = 5,
   parameter int unsigned          ABITS     = 7,
   parameter logic [IR_LENGTH-1:0] IR_DTMCS  = 5'h10,
   parameter logic [IR_LENGTH-1:0] IR_DMI    = 5'h11,
   parameter logic [2:0]           IDLE_HINT = 3'd1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IR_LENGTH-1:0] ir_i,
   input  logic                 trst_ni,
   input  logic                 capture_i,
   input  logic                 shift_i,
   input  logic                 update_i,
   input  logic                 td_i,
   output logic                 tdo_o,
   output logic                 dmi_req_valid,
   input  logic                 dmi_req_ready,
   output logic [ABITS-1:0]     dmi_req_addr,
   output logic [31:0]          dmi_req_data,
   output logic [1:0]           dmi_req_op,
   input  logic                 dmi_resp_valid,
   output logic                 dmi_resp_ready,
   input  logic [31:0]          dmi_resp_data,
   input  logic [1:0]           dmi_resp_op
);

   localparam int unsigned DMI_W = ABITS + 34;
   localparam logic [5:0]  ABITS_FIELD = 6'(ABITS);

   typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

   state_e             state_q;
   logic [31:0]        dtmcs_sr;
   logic [DMI_W-1:0]   dmi_sr;
   logic [1:0]         sticky_q, sticky_d;
   logic [31:0]        rdata_q;
   logic [ABITS-1:0]   addr_q;

   logic               sel_dtmcs, sel_dmi;
   logic               dtmcs_upd, dmireset, sticky_clr;
   logic               dmi_cap, dmi_upd, busy, busy_hit, dmi_accept;
   logic               resp_fire, resp_store;
   logic [31:0]        dtmcs_capture;
   logic [1:0]         upd_op;
   logic [31:0]        upd_data;
   logic [ABITS-1:0]   upd_addr;

   assign sel_dtmcs = (ir_i == IR_DTMCS);
   assign sel_dmi   = (ir_i == IR_DMI);

   assign tdo_o = sel_dtmcs ? dtmcs_sr[0] : (sel_dmi ? dmi_sr[0] : 1'b0);

   // {14'b0, dmihardreset, dmireset, 0, idle, dmistat, abits, version}
   assign dtmcs_capture = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_HINT, sticky_q, ABITS_FIELD, 4'd1};

   assign upd_op   = dmi_sr[1:0];
   assign upd_data = dmi_sr[33:2];
   assign upd_addr = dmi_sr[DMI_W-1:34];

   assign busy       = (state_q != StIdle);
   assign dtmcs_upd  = update_i && sel_dtmcs;
   assign dmireset   = dtmcs_upd && dtmcs_sr[16];
   assign dmi_cap    = capture_i && sel_dmi;
   assign dmi_upd    = update_i && sel_dmi;
   // Capturing while busy, or updating while busy with no prior error, flags busy.
   assign busy_hit   = (dmi_cap && busy) || (dmi_upd && (sticky_q == 2'd0) && busy);
   assign dmi_accept = dmi_upd && (sticky_q == 2'd0) && !busy &&
                       ((upd_op == 2'd1) || (upd_op == 2'd2));
   assign resp_fire  = (state_q == StResp) && dmi_resp_valid;

`ifdef ARMLEOCPU_JTAG_DTM_HARDRESET_EN
   logic hardreset, discard_q;
   assign hardreset  = !trst_ni || (dtmcs_upd && dtmcs_sr[17]);
   assign resp_store = resp_fire && !discard_q;
   assign sticky_clr = !trst_ni || dmireset || hardreset;
`else
   assign resp_store = resp_fire;
   assign sticky_clr = !trst_ni || dmireset;
`endif

   // Later assignments take priority: clears beat busy, busy beats a response error.
   always_comb begin
      sticky_d = sticky_q;
      if (resp_store && dmi_resp_op[1]) sticky_d = dmi_resp_op;
      if (busy_hit)                     sticky_d = 2'd3;
      if (sticky_clr)                   sticky_d = 2'd0;
   end

   // Shift registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dtmcs_sr <= '0;
         dmi_sr   <= '0;
      end else if (!trst_ni) begin
         dtmcs_sr <= '0;
         dmi_sr   <= '0;
      end else begin
         if (sel_dtmcs) begin
            if (capture_i)    dtmcs_sr <= dtmcs_capture;
            else if (shift_i) dtmcs_sr <= {td_i, dtmcs_sr[31:1]};
         end
         if (sel_dmi) begin
            if (capture_i)    dmi_sr <= {addr_q, rdata_q, busy ? 2'd3 : sticky_q};
            else if (shift_i) dmi_sr <= {td_i, dmi_sr[DMI_W-1:1]};
         end
      end
   end

   // DMI transaction FSM with registered bus outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         dmi_req_valid  <= 1'b0;
         dmi_resp_ready <= 1'b0;
         dmi_req_addr   <= '0;
         dmi_req_data   <= '0;
         dmi_req_op     <= '0;
         addr_q         <= '0;
         rdata_q        <= '0;
         sticky_q       <= '0;
`ifdef ARMLEOCPU_JTAG_DTM_HARDRESET_EN
         discard_q      <= 1'b0;
`endif
      end else begin
         sticky_q <= sticky_d;
         case (state_q)
            StIdle: begin
               if (dmi_accept) begin
                  dmi_req_addr  <= upd_addr;
                  dmi_req_data  <= upd_data;
                  dmi_req_op    <= upd_op;
                  addr_q        <= upd_addr;
                  dmi_req_valid <= 1'b1;
                  state_q       <= StReq;
               end
            end
            StReq: begin
               if (dmi_req_ready) begin
                  dmi_req_valid  <= 1'b0;
                  dmi_resp_ready <= 1'b1;
                  state_q        <= StResp;
               end
            end
            StResp: begin
               if (dmi_resp_valid) begin
                  dmi_resp_ready <= 1'b0;
                  state_q        <= StIdle;
                  if (resp_store) rdata_q <= dmi_resp_data;
               end
            end
            default: begin
               state_q        <= StIdle;
               dmi_req_valid  <= 1'b0;
               dmi_resp_ready <= 1'b0;
            end
         endcase
`ifdef ARMLEOCPU_JTAG_DTM_HARDRESET_EN
         // A response landing in the hardreset cycle already completes the
         // transfer, so only arm discard for a response still to come.
         if (resp_fire) discard_q <= 1'b0;
         if (hardreset && ((state_q == StReq) || ((state_q == StResp) && !dmi_resp_valid)))
            discard_q <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_armleocpu_jtag_dtm.sv
module tb_armleocpu_jtag_dtm;

   localparam logic [4:0] IR_DTMCS = 5'h10;
   localparam logic [4:0] IR_DMI   = 5'h11;
   localparam logic [31:0] DTMCS_BASE = 32'h0000_1071;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  ir_i;
   logic        trst_ni, capture_i, shift_i, update_i, td_i;
   logic        tdo_o;
   logic        dmi_req_valid, dmi_req_ready;
   logic [6:0]  dmi_req_addr;
   logic [31:0] dmi_req_data;
   logic [1:0]  dmi_req_op;
   logic        dmi_resp_valid, dmi_resp_ready;
   logic [31:0] dmi_resp_data;
   logic [1:0]  dmi_resp_op;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [6:0]  addr;
      logic [31:0] data;
      logic [1:0]  op;
   } req_t;
   req_t exp_q[$];

   typedef struct {
      logic [1:0]  op;
      logic [6:0]  addr;
      logic [31:0] data;
      int          rdy;
      logic [31:0] rdata;
      logic [1:0]  rop;
      logic [1:0]  exp_op;
   } vec_t;
   vec_t vecs[5];

   armleocpu_jtag_dtm dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ir_i           (ir_i),
      .trst_ni        (trst_ni),
      .capture_i      (capture_i),
      .shift_i        (shift_i),
      .update_i       (update_i),
      .td_i           (td_i),
      .tdo_o          (tdo_o),
      .dmi_req_valid  (dmi_req_valid),
      .dmi_req_ready  (dmi_req_ready),
      .dmi_req_addr   (dmi_req_addr),
      .dmi_req_data   (dmi_req_data),
      .dmi_req_op     (dmi_req_op),
      .dmi_resp_valid (dmi_resp_valid),
      .dmi_resp_ready (dmi_resp_ready),
      .dmi_resp_data  (dmi_resp_data),
      .dmi_resp_op    (dmi_resp_op)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   // Full DR scan: capture, n shifts (LSB first), update.
   task automatic scan(input logic [4:0] ir, input int n, input logic [63:0] din,
                       input bit resp_at_cap, output logic [63:0] dout);
      dout = '0;
      ir_i = ir;
      capture_i = 1'b1;
      if (resp_at_cap) dmi_resp_valid = 1'b1;
      tick();
      capture_i = 1'b0;
      dmi_resp_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         dout[i] = tdo_o;
         td_i = din[i];
         shift_i = 1'b1;
         tick();
         shift_i = 1'b0;
      end
      update_i = 1'b1;
      tick();
      update_i = 1'b0;
   endtask

   task automatic dtmcs_scan(input logic [31:0] din, output logic [31:0] dout);
      logic [63:0] d, o;
      d = '0;
      d[31:0] = din;
      scan(IR_DTMCS, 32, d, 1'b0, o);
      dout = o[31:0];
   endtask

   task automatic dmi_scan(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                           input bit rac, output logic [6:0] ca, output logic [31:0] cd,
                           output logic [1:0] co);
      logic [63:0] d, o;
      d = '0;
      d[40:0] = {addr, data, op};
      scan(IR_DMI, 41, d, rac, o);
      co = o[1:0];
      cd = o[33:2];
      ca = o[40:34];
   endtask

   task automatic check_cap(input string name, input logic [6:0] ca, input logic [31:0] cd,
                            input logic [1:0] co, input logic [6:0] ea, input logic [31:0] ed,
                            input logic [1:0] eo);
      check({name, ".addr"}, 64'(ca), 64'(ea));
      check({name, ".data"}, 64'(cd), 64'(ed));
      check({name, ".op"}, 64'(co), 64'(eo));
   endtask

   // Debug Module side: hold ready low for 'delay' cycles, checking the
   // held payload against the scoreboard, then complete the handshake.
   task automatic dm_accept(input int delay);
      req_t e;
      int   waited;
      check("req_valid_rise", 64'(dmi_req_valid), 64'd1);
      waited = 0;
      while (!dmi_req_valid && waited < 50) begin
         tick();
         waited++;
      end
      if (!dmi_req_valid) begin
         check("req_timeout", 64'd0, 64'd1);
         return;
      end
      if (exp_q.size() == 0) begin
         check("req_unexpected", 64'd1, 64'd0);
         return;
      end
      e = exp_q.pop_front();
      for (int d = 0; d < delay; d++) begin
         check("req_hold.valid", 64'(dmi_req_valid), 64'd1);
         check("req_hold.payload", {dmi_req_addr, dmi_req_data, dmi_req_op},
               {e.addr, e.data, e.op});
         tick();
      end
      check("req.payload", {dmi_req_addr, dmi_req_data, dmi_req_op}, {e.addr, e.data, e.op});
      dmi_req_ready = 1'b1;
      tick();
      dmi_req_ready = 1'b0;
      check("req_valid_drop", 64'(dmi_req_valid), 64'd0);
   endtask

   task automatic dm_respond(input logic [31:0] data, input logic [1:0] op);
      check("resp_ready", 64'(dmi_resp_ready), 64'd1);
      dmi_resp_data  = data;
      dmi_resp_op    = op;
      dmi_resp_valid = 1'b1;
      tick();
      dmi_resp_valid = 1'b0;
      check("resp_ready_drop", 64'(dmi_resp_ready), 64'd0);
   endtask

   task automatic no_req(input string name, input int n);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (dmi_req_valid) seen = 1'b1;
         tick();
      end
      check(name, 64'(seen), 64'd0);
   endtask

   task automatic dmi_issue(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
      logic [6:0]  ca;
      logic [31:0] cd;
      logic [1:0]  co;
      req_t r;
      dmi_scan(op, addr, data, 1'b0, ca, cd, co);
      r.addr = addr;
      r.data = data;
      r.op   = op;
      exp_q.push_back(r);
   endtask

   logic [31:0] w;
   logic [6:0]  ca;
   logic [31:0] cd;
   logic [1:0]  co;

   initial begin
      vecs[0] = '{op: 2'd2, addr: 7'h10, data: 32'h0000_0001, rdy: 3,
                  rdata: 32'h0000_0000, rop: 2'd0, exp_op: 2'd0};
      vecs[1] = '{op: 2'd1, addr: 7'h11, data: 32'h0000_0000, rdy: 0,
                  rdata: 32'hDEAD_BEEF, rop: 2'd0, exp_op: 2'd0};
      vecs[2] = '{op: 2'd1, addr: 7'h04, data: 32'h0000_0000, rdy: 1,
                  rdata: 32'hCAFE_F00D, rop: 2'd1, exp_op: 2'd0};
      vecs[3] = '{op: 2'd2, addr: 7'h7F, data: 32'hA5A5_A5A5, rdy: 2,
                  rdata: 32'h0000_0000, rop: 2'd2, exp_op: 2'd2};
      vecs[4] = '{op: 2'd1, addr: 7'h22, data: 32'h0000_0000, rdy: 0,
                  rdata: 32'h1357_9BDF, rop: 2'd3, exp_op: 2'd3};

      rst_n = 1'b0; ir_i = 5'h01; trst_ni = 1'b1;
      capture_i = 1'b0; shift_i = 1'b0; update_i = 1'b0; td_i = 1'b0;
      dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp_data = '0; dmi_resp_op = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      ir_i = IR_DTMCS;
      #1;
      check("rst.tdo", 64'(tdo_o), 64'd0);
      check("rst.req_valid", 64'(dmi_req_valid), 64'd0);
      check("rst.req_payload", {dmi_req_addr, dmi_req_data, dmi_req_op}, 64'd0);
      check("rst.resp_ready", 64'(dmi_resp_ready), 64'd0);

      // DTMCS readout
      dtmcs_scan(32'h0, w);
      check("dtmcs.value", 64'(w), 64'(DTMCS_BASE));

      // Table-driven transactions
      for (int i = 0; i < 5; i++) begin
         dmi_issue(vecs[i].op, vecs[i].addr, vecs[i].data);
         dm_accept(vecs[i].rdy);
         dm_respond(vecs[i].rdata, vecs[i].rop);
         dmi_scan(2'd0, 7'h0, 32'h0, 1'b0, ca, cd, co);
         check_cap($sformatf("vec%0d.cap", i), ca, cd, co,
                   vecs[i].addr, vecs[i].rdata, vecs[i].exp_op);
         if (vecs[i].exp_op != 2'd0) begin
            dtmcs_scan(32'h0, w);
            check($sformatf("vec%0d.dmistat", i), 64'(w),
                  64'(DTMCS_BASE | (32'(vecs[i].exp_op) << 10)));
            dmi_scan(2'd2, 7'h01, 32'hFFFF_0000, 1'b0, ca, cd, co);
            no_req($sformatf("vec%0d.sticky_blocks", i), 5);
            dtmcs_scan(32'h0001_0000, w);
            dmi_scan(2'd0, 7'h0, 32'h0, 1'b0, ca, cd, co);
            check($sformatf("vec%0d.cleared", i), 64'(co), 64'd0);
         end
      end

      // Update while a response is pending
      dmi_issue(2'd1, 7'h05, 32'h0);
      dm_accept(0);
      dmi_scan(2'd1, 7'h06, 32'h0, 1'b0, ca, cd, co);
      check_cap("busy.cap", ca, cd, co, 7'h05, 32'h1357_9BDF, 2'd3);
      no_req("busy.no_req", 3);
      dm_respond(32'h1111_2222, 2'd0);
      no_req("busy.after_resp", 3);
      dmi_scan(2'd1, 7'h06, 32'h0, 1'b0, ca, cd, co);
      check_cap("busy.sticky", ca, cd, co, 7'h05, 32'h1111_2222, 2'd3);
      no_req("busy.update_ignored", 5);
      dtmcs_scan(32'h0001_0000, w);
      dmi_scan(2'd0, 7'h0, 32'h0, 1'b0, ca, cd, co);
      check("busy.cleared", 64'(co), 64'd0);

      // Response coincident with capture: capture still reports busy
      dmi_issue(2'd1, 7'h07, 32'h0);
      dm_accept(1);
      dmi_resp_data = 32'h0BAD_F00D;
      dmi_resp_op   = 2'd0;
      dmi_scan(2'd0, 7'h0, 32'h0, 1'b1, ca, cd, co);
      check_cap("coinc.cap", ca, cd, co, 7'h07, 32'h1111_2222, 2'd3);
      check("coinc.idle", 64'(dmi_resp_ready), 64'd0);
      dtmcs_scan(32'h0001_0000, w);
      dmi_scan(2'd0, 7'h0, 32'h0, 1'b0, ca, cd, co);
      check_cap("coinc.after", ca, cd, co, 7'h07, 32'h0BAD_F00D, 2'd0);

      // Hardreset during RESP
      dmi_issue(2'd2, 7'h03, 32'h0000_0055);
      dm_accept(0);
      dtmcs_scan(32'h0002_0000, w);
      dm_respond(32'h1234_5678, 2'd2);
      dmi_scan(2'd0, 7'h0, 32'h0, 1'b0, ca, cd, co);
`ifdef ARMLEOCPU_JTAG_DTM_HARDRESET_EN
      check_cap("hardreset.cap", ca, cd, co, 7'h03, 32'h0BAD_F00D, 2'd0);
`else
      check_cap("hardreset.cap", ca, cd, co, 7'h03, 32'h1234_5678, 2'd2);
      dtmcs_scan(32'h0001_0000, w);
`endif
      dmi_issue(2'd1, 7'h09, 32'h0);
      dm_accept(0);
      dm_respond(32'h600D_CAFE, 2'd0);
      dmi_scan(2'd0, 7'h0, 32'h0, 1'b0, ca, cd, co);
      check_cap("post_hardreset.cap", ca, cd, co, 7'h09, 32'h600D_CAFE, 2'd0);

      // Unselected IR and trst
      dtmcs_scan(32'h0, w);
      ir_i = IR_DTMCS;
      capture_i = 1'b1;
      tick();
      capture_i = 1'b0;
      check("sel.tdo_dtmcs", 64'(tdo_o), 64'd1);
      ir_i = 5'h01;
      #1;
      check("sel.tdo_other", 64'(tdo_o), 64'd0);
      ir_i = IR_DTMCS;
      #1;
      check("sel.tdo_back", 64'(tdo_o), 64'd1);
      trst_ni = 1'b0;
      tick();
      trst_ni = 1'b1;
      check("trst.tdo", 64'(tdo_o), 64'd0);
      check("scoreboard.empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
